// File: rtl/lcd_overlay_pkg.sv
// Shared types and constants for the LCD box-outline overlay.
package lcd_overlay_pkg;

  localparam int unsigned LCD_H_W   = 9;
  localparam int unsigned LCD_PIX_W = 8;

  localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

  typedef struct packed {
    logic               en;
    logic [LCD_H_W-1:0] upper;
    logic [LCD_H_W-1:0] lower;
    logic [LCD_H_W-1:0] left;
    logic [LCD_H_W-1:0] right;
  } box_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_st_e;

endpackage

// File: rtl/lcd_box_hit.sv
// Combinational outline hit test for one box; bands are drawn inward from each bound.
module lcd_box_hit
  import lcd_overlay_pkg::*;
#(
  parameter int unsigned THICK = 2
) (
  input  box_t               i_box,
  input  logic [LCD_H_W-1:0] i_hcount,
  input  logic [LCD_H_W-1:0] i_lcount,
  output logic               o_hit
);

  localparam int unsigned   TM1 = THICK - 1;
  localparam logic [LCD_H_W:0] T1 = TM1[LCD_H_W:0];

  logic [LCD_H_W:0] w_h, w_l, w_u, w_lo, w_le, w_r;
  logic             w_valid, w_in_rows, w_in_cols, w_band;

  assign w_h  = {1'b0, i_hcount};
  assign w_l  = {1'b0, i_lcount};
  assign w_u  = {1'b0, i_box.upper};
  assign w_lo = {1'b0, i_box.lower};
  assign w_le = {1'b0, i_box.left};
  assign w_r  = {1'b0, i_box.right};

  assign w_valid   = i_box.en && (w_u <= w_lo) && (w_le <= w_r);
  assign w_in_rows = (w_l >= w_u) && (w_l <= w_lo);
  assign w_in_cols = (w_h >= w_le) && (w_h <= w_r);

  // Each band is clipped to the box itself, so thin boxes fill instead of spilling past a bound.
  assign w_band = (w_l <= w_u + T1) || (w_l + T1 >= w_lo) ||
                  (w_h <= w_le + T1) || (w_h + T1 >= w_r);

  assign o_hit = w_valid && w_in_rows && w_in_cols && w_band;

endmodule

// File: rtl/lcd_box_overlay.sv
// Box-outline overlay on the grayscale LCD stream: shadow/active box banks with
// frame-aligned commit, and a 2-stage hit/colour pipeline.
module lcd_box_overlay
  import lcd_overlay_pkg::*;
#(
  parameter int unsigned     H_W       = LCD_H_W,
  parameter int unsigned     PIX_W     = LCD_PIX_W,
  parameter int unsigned     NUM_BOX   = 4,
  parameter int unsigned     THICK     = 2,
  parameter logic [3*PIX_W-1:0] BOX_COLOR = COLOR_BLUE,
  localparam int unsigned    IDX_W     = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [H_W-1:0]   hcount,
  input  logic [H_W-1:0]   lcount,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] datain,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [H_W-1:0]   cfg_upper,
  input  logic [H_W-1:0]   cfg_lower,
  input  logic [H_W-1:0]   cfg_left,
  input  logic [H_W-1:0]   cfg_right,
  input  logic             cfg_commit,
  output logic [PIX_W-1:0] lcd_out_rgb_r,
  output logic [PIX_W-1:0] lcd_out_rgb_g,
  output logic [PIX_W-1:0] lcd_out_rgb_b,
  output logic             out_valid
);

  box_t         r_shadow [NUM_BOX];
  box_t         r_active [NUM_BOX];
  commit_st_e   r_state, w_state_nx;
  logic         w_copy, w_wr;

  logic [NUM_BOX-1:0] w_hit, r_hit;
  logic [PIX_W-1:0]   r_data;
  logic               r_vld;

  logic [IDX_W-1:0]   w_win;
  logic               w_any;
  logic [3*PIX_W-1:0] w_palette [NUM_BOX];

  logic [PIX_W-1:0]   r_out_r, r_out_g, r_out_b;
  logic               r_out_vld;

  // Commit FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // A commit coinciding with frame_start only arms; the copy waits for the next frame.
  always_comb begin
    w_state_nx = r_state;
    w_copy     = 1'b0;
    case (r_state)
      ST_IDLE:    if (cfg_commit) w_state_nx = ST_PENDING;
      ST_PENDING: if (frame_start) begin
        w_copy     = 1'b1;
        w_state_nx = cfg_commit ? ST_PENDING : ST_IDLE;
      end
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  assign cfg_ready = (r_state == ST_IDLE);
  assign w_wr      = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_BOX; k++) r_shadow[k] <= '0;
    end else if (w_wr && (32'(cfg_idx) < NUM_BOX)) begin
      r_shadow[cfg_idx] <= '{en: cfg_en, upper: cfg_upper, lower: cfg_lower,
                             left: cfg_left, right: cfg_right};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_BOX; k++) r_active[k] <= '0;
    end else if (w_copy) begin
      r_active <= r_shadow;
    end
  end

  for (genvar k = 0; k < NUM_BOX; k++) begin : g_box
    lcd_box_hit #(.THICK(THICK)) u_hit (
      .i_box    (r_active[k]),
      .i_hcount (hcount),
      .i_lcount (lcount),
      .o_hit    (w_hit[k])
    );
    assign w_palette[k] = BOX_COLOR;
  end

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= '0;
      r_data <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_hit  <= w_hit;
      r_data <= datain;
      r_vld  <= pix_valid;
    end
  end

  // Lowest-index hit wins; the palette is indexed so per-box colours can be added later.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < NUM_BOX; k++) begin
      if (r_hit[k] && !w_any) begin
        w_win = IDX_W'(k);
        w_any = 1'b1;
      end
    end
  end

  // Stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_r   <= '0;
      r_out_g   <= '0;
      r_out_b   <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= r_vld;
      if (r_vld) begin
        if (w_any) {r_out_r, r_out_g, r_out_b} <= w_palette[w_win];
        else       {r_out_r, r_out_g, r_out_b} <= {r_data, r_data, r_data};
      end
    end
  end

  assign lcd_out_rgb_r = r_out_r;
  assign lcd_out_rgb_g = r_out_g;
  assign lcd_out_rgb_b = r_out_b;
  assign out_valid     = r_out_vld;

endmodule

// File: tb/tb_lcd_box_overlay.sv
// Self-checking bench for lcd_box_overlay: vector tables plus commit/reset sequences.
module tb_lcd_box_overlay;

  localparam logic [23:0] BLUE = 24'h0000FF;

  logic       clk;
  logic       rst_n;
  logic [8:0] hcount, lcount;
  logic       pix_valid, frame_start;
  logic [7:0] datain;
  logic       cfg_valid, cfg_ready;
  logic [1:0] cfg_idx;
  logic       cfg_en;
  logic [8:0] cfg_upper, cfg_lower, cfg_left, cfg_right;
  logic       cfg_commit;
  logic [7:0] lcd_out_rgb_r, lcd_out_rgb_g, lcd_out_rgb_b;
  logic       out_valid;

  lcd_box_overlay #(
    .H_W      (9),
    .PIX_W    (8),
    .NUM_BOX  (4),
    .THICK    (2),
    .BOX_COLOR(24'h0000FF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcount       (hcount),
    .lcount       (lcount),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .datain       (datain),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_idx      (cfg_idx),
    .cfg_en       (cfg_en),
    .cfg_upper    (cfg_upper),
    .cfg_lower    (cfg_lower),
    .cfg_left     (cfg_left),
    .cfg_right    (cfg_right),
    .cfg_commit   (cfg_commit),
    .lcd_out_rgb_r(lcd_out_rgb_r),
    .lcd_out_rgb_g(lcd_out_rgb_g),
    .lcd_out_rgb_b(lcd_out_rgb_b),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    int          cyc;
  } exp_t;
  exp_t        sbq[$];
  logic [23:0] last_rgb = '0;

  typedef struct {
    int h;
    int l;
    int d;
    bit blue;
  } vec_t;

  // Output side of the scoreboard: every valid pixel pops and compares, idle cycles check hold.
  always @(negedge clk) begin
    logic [23:0] act;
    exp_t        e;
    if (rst_n) begin
      act = {lcd_out_rgb_r, lcd_out_rgb_g, lcd_out_rgb_b};
      if (out_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid actual=%06h required=no output", act);
        end else begin
          e = sbq.pop_front();
          if (act !== e.rgb || cyc != e.cyc + 2) begin
            failures++;
            $display("FAIL pixel actual=%06h@%0d required=%06h@%0d", act, cyc, e.rgb, e.cyc + 2);
          end
          last_rgb = e.rgb;
        end
      end else begin
        checks++;
        if (act !== last_rgb) begin
          failures++;
          $display("FAIL hold actual=%06h required=%06h", act, last_rgb);
        end
        if (sbq.size() > 0 && sbq[0].cyc + 2 <= cyc) begin
          failures++;
          $display("FAIL missing_valid actual=0 required=1 (driven at cycle %0d)", sbq[0].cyc);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc_drive(input bit pv, input bit fs, input logic [8:0] h, input logic [8:0] l,
                           input logic [7:0] d, input logic [23:0] exp, input bit commit);
    @(negedge clk);
    pix_valid   = pv;
    frame_start = fs;
    hcount      = h;
    lcount      = l;
    datain      = d;
    cfg_valid   = 1'b0;
    cfg_commit  = commit;
    if (pv) sbq.push_back('{rgb: exp, cyc: cyc});
  endtask

  task automatic pix(input int h, input int l, input int d, input bit blue);
    logic [7:0] d8;
    d8 = 8'(d);
    cyc_drive(1'b1, 1'b0, 9'(h), 9'(l), d8, blue ? BLUE : {d8, d8, d8}, 1'b0);
  endtask

  task automatic fs_pix(input bit commit);
    cyc_drive(1'b1, 1'b1, 9'd0, 9'd0, 8'h10, 24'h101010, commit);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drive(1'b0, 1'b0, 9'd0, 9'd0, 8'h00, 24'h0, 1'b0);
  endtask

  task automatic ready_idle(input bit exp, input string nm);
    cyc_drive(1'b0, 1'b0, 9'd0, 9'd0, 8'h00, 24'h0, 1'b0);
    chk(nm, 32'(cfg_ready), 32'(exp));
  endtask

  task automatic cfg_write(input int idx, input bit en, input int u, input int lo,
                           input int le, input int r, input bit commit);
    int n;
    @(negedge clk);
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b1;
    cfg_idx     = 2'(idx);
    cfg_en      = en;
    cfg_upper   = 9'(u);
    cfg_lower   = 9'(lo);
    cfg_left    = 9'(le);
    cfg_right   = 9'(r);
    cfg_commit  = commit;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_write_ready", 32'(cfg_ready), 32'd1);
  endtask

  vec_t t2[14] = '{
    '{35, 10, 8'h21, 1'b1}, '{35, 11, 8'h22, 1'b1}, '{35, 12, 8'h23, 1'b0},
    '{29, 15, 8'h24, 1'b0}, '{39, 15, 8'h25, 1'b1}, '{40, 15, 8'h26, 1'b1},
    '{30, 15, 8'h27, 1'b1}, '{31, 15, 8'h28, 1'b1}, '{32, 15, 8'h29, 1'b0},
    '{35, 19, 8'h2A, 1'b1}, '{35, 20, 8'h2B, 1'b1}, '{35, 21, 8'h2C, 1'b0},
    '{41, 15, 8'h2D, 1'b0}, '{35,  9, 8'h2E, 1'b0}
  };

  vec_t t5[20] = '{
    '{65,   5, 8'h41, 1'b1}, '{65,   6, 8'h42, 1'b1}, '{60,   5, 8'h43, 1'b1},
    '{59,   5, 8'h44, 1'b0}, '{71,   6, 8'h45, 1'b0}, '{70,   6, 8'h46, 1'b1},
    '{65,   7, 8'h47, 1'b0}, '{65,   4, 8'h48, 1'b0},
    '{200,  0, 8'h51, 1'b1}, '{205,  0, 8'h52, 1'b1}, '{205,  4, 8'h53, 1'b0},
    '{200,  4, 8'h54, 1'b1}, '{205,  8, 8'h55, 1'b1}, '{205,  9, 8'h56, 1'b0},
    '{200, 511, 8'h57, 1'b0}, '{199,  0, 8'h58, 1'b0},
    '{0,   99, 8'h61, 1'b0}, '{0,  100, 8'h62, 1'b0}, '{25, 100, 8'h63, 1'b0},
    '{50,  99, 8'h64, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {hcount, lcount, pix_valid, frame_start, datain} = '0;
    {cfg_valid, cfg_idx, cfg_en, cfg_upper, cfg_lower, cfg_left, cfg_right, cfg_commit} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rgb", 32'({lcd_out_rgb_r, lcd_out_rgb_g, lcd_out_rgb_b}), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(cfg_ready), 32'd1);

    // Plain gray stream with a bubble
    cyc_drive(1'b1, 1'b1, 9'd0, 9'd0, 8'h55, 24'h555555, 1'b0);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) idle(1);
      pix(i * 37, i * 11, 8'h55, 1'b0);
    end
    idle(3);

    // Box 0 and the edge table
    cfg_write(0, 1'b1, 10, 20, 30, 40, 1'b0);
    cyc_drive(1'b0, 1'b0, 9'd0, 9'd0, 8'h00, 24'h0, 1'b1);
    ready_idle(1'b0, "ready_low_after_commit");
    fs_pix(1'b0);
    for (int i = 0; i < 14; i++) pix(t2[i].h, t2[i].l, t2[i].d, t2[i].blue);
    idle(3);

    // Commit mid-frame: current frame unchanged, next frame shows box 1
    cfg_write(1, 1'b1, 50, 60, 100, 120, 1'b0);
    fs_pix(1'b0);
    pix(100, 55, 8'h31, 1'b0);
    cyc_drive(1'b0, 1'b0, 9'd0, 9'd0, 8'h00, 24'h0, 1'b1);
    ready_idle(1'b0, "ready_commit_plus1");
    pix(100, 55, 8'h32, 1'b0);
    pix(110, 50, 8'h33, 1'b0);
    ready_idle(1'b0, "ready_still_pending");
    fs_pix(1'b0);
    ready_idle(1'b1, "ready_fs_plus1");
    pix(100, 55, 8'h34, 1'b1);
    pix(110, 50, 8'h35, 1'b1);
    pix(110, 52, 8'h36, 1'b0);
    idle(3);

    // Commit together with frame_start: applies one frame later
    cfg_write(2, 1'b1, 80, 90, 10, 20, 1'b0);
    fs_pix(1'b1);
    ready_idle(1'b0, "ready_commit_with_fs");
    pix(10, 85, 8'h37, 1'b0);
    pix(15, 80, 8'h38, 1'b0);
    fs_pix(1'b0);
    ready_idle(1'b1, "ready_after_late_fs");
    pix(10, 85, 8'h39, 1'b1);
    pix(15, 85, 8'h3A, 1'b0);
    pix(15, 80, 8'h3B, 1'b1);
    idle(3);

    // Thin box, box at row 0, inverted box; last write shares its cycle with the commit
    cfg_write(1, 1'b1, 0, 8, 200, 210, 1'b0);
    cfg_write(2, 1'b1, 100, 99, 0, 50, 1'b0);
    cfg_write(3, 1'b1, 5, 6, 60, 70, 1'b1);
    ready_idle(1'b0, "ready_write_with_commit");
    fs_pix(1'b0);
    for (int i = 0; i < 20; i++) pix(t5[i].h, t5[i].l, t5[i].d, t5[i].blue);
    idle(3);

    // Asynchronous reset in the middle of a frame
    fs_pix(1'b0);
    pix(35, 10, 8'h71, 1'b1);
    pix(65, 5, 8'h72, 1'b1);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sbq.delete();
    last_rgb = '0;
    #1;
    chk("midreset_rgb", 32'({lcd_out_rgb_r, lcd_out_rgb_g, lcd_out_rgb_b}), 32'd0);
    chk("midreset_valid", 32'(out_valid), 32'd0);
    chk("midreset_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fs_pix(1'b0);
    pix(35, 10, 8'h73, 1'b0);
    pix(65, 5, 8'h74, 1'b0);
    cyc_drive(1'b0, 1'b0, 9'd0, 9'd0, 8'h00, 24'h0, 1'b1);
    fs_pix(1'b0);
    pix(35, 10, 8'h75, 1'b0);
    pix(200, 0, 8'h76, 1'b0);
    idle(4);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
